alu_operand_stage: RTL and testbench

- Issue stage directly upstream of the ALU. Accepts one decoded instruction per cycle on a valid/ready handshake and reads rs1/rs2 from the register file.
- Selects register, immediate or PC operands, then drives registered instr/op1/op2/enable into the ALU.
- Tracks the destination of in-flight ALU instructions. Stalls or forwards the ALU result so a dependent instruction never sees a stale operand.

---
 rtl/alu_operand_stage.sv | 153 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand/issue stage: reads sources, resolves in-flight writers, registers operands into the ALU.
// Optional FORWARD_EN: forward alu_result on a P1 hit instead of stalling for writeback.
module alu_operand_stage #(
  parameter int trace    = 0,
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic [31:0] alu_result,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic        alu_enable
);

  localparam int REG_W = $clog2(NUM_REGS);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  opcode_e            opcode;
  logic               is_alu, uses_rs1, uses_rs2;
  logic [REG_W-1:0]   rs1, rs2, rd;
  logic               p0_valid, p1_valid;
  logic [REG_W-1:0]   p0_rd, p1_rd;
  logic               p0_hit1, p0_hit2, p1_hit1, p1_hit2;
  logic               stall, accept;
  logic [31:0]        rs1_val, rs2_val;
  logic [31:0]        op1_next, op2_next;

  assign opcode      = opcode_e'(in_instr[6:0]);
  assign rs1         = in_instr[15 +: REG_W];
  assign rs2         = in_instr[20 +: REG_W];
  assign rd          = in_instr[7 +: REG_W];
  assign rf_rs1_addr = in_instr[19:15];
  assign rf_rs2_addr = in_instr[24:20];

  always_comb begin
    is_alu   = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        is_alu   = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        is_alu   = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: is_alu = 1'b1;
      default: ;
    endcase
  end

  // x0 never hazards, so the rs != 0 term also gives x0 top priority
  assign p0_hit1 = uses_rs1 && (rs1 != '0) && p0_valid && (p0_rd == rs1);
  assign p0_hit2 = uses_rs2 && (rs2 != '0) && p0_valid && (p0_rd == rs2);
  assign p1_hit1 = uses_rs1 && (rs1 != '0) && p1_valid && (p1_rd == rs1);
  assign p1_hit2 = uses_rs2 && (rs2 != '0) && p1_valid && (p1_rd == rs2);

`ifdef FORWARD_EN
  assign stall = p0_hit1 || p0_hit2;

  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
    if (rs1 == '0)   rs1_val = '0;
    else if (p1_hit1) rs1_val = alu_result;
    if (rs2 == '0)   rs2_val = '0;
    else if (p1_hit2) rs2_val = alu_result;
  end
`else
  logic unused_alu_result;
  assign unused_alu_result = ^alu_result;

  assign stall = p0_hit1 || p0_hit2 || p1_hit1 || p1_hit2;

  always_comb begin
    rs1_val = rf_rs1_data;
    rs2_val = rf_rs2_data;
    if (rs1 == '0) rs1_val = '0;
    if (rs2 == '0) rs2_val = '0;
  end
`endif

  assign in_ready = !rst && !stall;
  assign accept   = in_valid && in_ready;

  always_comb begin
    op1_next = rs1_val;
    op2_next = rs2_val;
    case (opcode)
      OPC_OP_IMM: op2_next = {{20{in_instr[31]}}, in_instr[31:20]};
      OPC_LUI: begin
        op1_next = {in_instr[31:12], 12'b0};
        op2_next = '0;
      end
      OPC_AUIPC: begin
        op1_next = {in_instr[31:12], 12'b0};
        op2_next = in_pc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_enable <= 1'b0;
      alu_instr  <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      p0_valid   <= 1'b0;
      p0_rd      <= '0;
      p1_valid   <= 1'b0;
      p1_rd      <= '0;
    end else begin
      p1_valid <= p0_valid;
      p1_rd    <= p0_rd;
      if (accept && is_alu) begin
        alu_enable <= 1'b1;
        alu_instr  <= in_instr;
        alu_op1    <= op1_next;
        alu_op2    <= op2_next;
        p0_valid   <= (rd != '0);
        p0_rd      <= rd;
      end else begin
        alu_enable <= 1'b0;
        p0_valid   <= 1'b0;
      end
    end
  end

  if (trace != 0) begin : g_trace
    always_ff @(posedge clk) begin
      if (!rst && accept) assert (!$isunknown(in_instr));
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: ALU/regfile/writeback environment plus an in-order golden model scoreboard.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [31:0] alu_result;
  logic [31:0] alu_instr, alu_op1, alu_op2;
  logic        alu_enable;

  int checks = 0;
  int errors = 0;
  logic sb_on = 1'b0;
  logic [95:0] sb_q[$];

`ifdef FORWARD_EN
  localparam int RAW_BUBBLES = 1;
`else
  localparam int RAW_BUBBLES = 2;
`endif

  alu_operand_stage #(.trace(0), .NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .alu_result(alu_result), .alu_instr(alu_instr),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_enable(alu_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_fn(input logic [31:0] ins, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [6:0] opc;
    logic [2:0] f3;
    opc = ins[6:0];
    f3  = ins[14:12];
    if (opc != 7'b0110011 && opc != 7'b0010011) return a + b;
    case (f3)
      3'b000:  return (opc == 7'b0110011 && ins[30]) ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // Environment: registered ALU result, register file written one cycle later.
  logic [31:0] env_rf [32];
  logic        wb_valid;
  logic [4:0]  wb_rd;

  assign rf_rs1_data = env_rf[rf_rs1_addr];
  assign rf_rs2_data = env_rf[rf_rs2_addr];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result <= '0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
    end else begin
      wb_valid <= alu_enable;
      wb_rd    <= alu_instr[11:7];
      if (alu_enable) alu_result <= alu_fn(alu_instr, alu_op1, alu_op2);
      if (wb_valid && wb_rd != 5'd0) env_rf[wb_rd] <= alu_result;
    end
  end

  // x0 data from the regfile is deliberately garbage
  initial begin
    env_rf[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < 32; i++) env_rf[i] = '0;
  end

  // Golden in-order model
  logic [31:0] g_rf [32];

  function automatic logic [31:0] r_type(input logic [6:0] f7, input int rs2, input int rs1,
                                         input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_type(input logic [11:0] imm, input int rs1,
                                         input logic [2:0] f3, input int rd);
    return {imm, 5'(rs1), f3, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] u_type(input logic [19:0] imm, input int rd, input logic [6:0] opc);
    return {imm, 5'(rd), opc};
  endfunction

  task automatic golden(input logic [31:0] ins, input logic [31:0] pc);
    logic [31:0] a, b, r;
    case (ins[6:0])
      7'b0110011: begin a = g_rf[ins[19:15]]; b = g_rf[ins[24:20]]; end
      7'b0010011: begin a = g_rf[ins[19:15]]; b = {{20{ins[31]}}, ins[31:20]}; end
      7'b0110111: begin a = {ins[31:12], 12'b0}; b = '0; end
      7'b0010111: begin a = {ins[31:12], 12'b0}; b = pc; end
      default: return;
    endcase
    r = alu_fn(ins, a, b);
    if (ins[11:7] != 5'd0) g_rf[ins[11:7]] = r;
    sb_q.push_back({ins, a, b});
  endtask

  // Called at a negedge; returns after the accepting posedge, at the next negedge.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, output int stalls);
    golden(ins, pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    stalls   = 0;
    #1;
    while (!in_ready && stalls < 10) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(stalls), 32'd0);
      $display("FAIL accept_timeout stuck stall");
      $fatal(1, "in_ready never rose");
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (sb_on && !rst && alu_enable) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_issue", alu_instr, 32'hFFFF_FFFF);
      end else begin
        logic [95:0] e;
        e = sb_q.pop_front();
        check("sb_instr", alu_instr, e[95:64]);
        check("sb_op1", alu_op1, e[63:32]);
        check("sb_op2", alu_op2, e[31:0]);
      end
    end
  end

  initial begin
    int s, s2;
    logic [31:0] pc;
    for (int i = 0; i < 32; i++) g_rf[i] = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    in_instr = i_type(12'd5, 0, 3'b000, 1);
    #1;
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_enable", {31'b0, alu_enable}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("pre_rst_enable", {31'b0, alu_enable}, 32'd1);
    check("pre_rst_op2", alu_op2, 32'd5);
    in_instr = i_type(12'd7, 0, 3'b000, 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_enable", {31'b0, alu_enable}, 32'd0);
    check("async_rst_op1", alu_op1, 32'd0);
    check("async_rst_op2", alu_op2, 32'd0);
    check("async_rst_instr", alu_instr, 32'd0);
    check("async_rst_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_on = 1'b1;
    @(negedge clk);

    issue(i_type(12'd5, 0, 3'b000, 1), 32'h0, s);
    issue(i_type(12'd7, 0, 3'b000, 2), 32'h4, s2);
    check("indep_stall_a", 32'(s), 32'd0);
    check("indep_stall_b", 32'(s2), 32'd0);

    issue(i_type(12'd5, 0, 3'b000, 1), 32'h8, s);
    issue(r_type(7'h00, 1, 1, 3'b000, 3), 32'hC, s);
    check("raw_p0_bubbles", 32'(s), 32'(RAW_BUBBLES));

    issue(i_type(12'd9, 0, 3'b000, 1), 32'h10, s);
    issue(i_type(12'd1, 0, 3'b000, 4), 32'h14, s);
    issue(r_type(7'h20, 4, 1, 3'b000, 5), 32'h18, s);
    check("p1_fwd_bubbles", 32'(s), 32'(RAW_BUBBLES));

    issue(i_type(12'd3, 0, 3'b000, 0), 32'h1C, s);
    issue(r_type(7'h00, 0, 0, 3'b000, 6), 32'h20, s);
    check("x0_no_stall", 32'(s), 32'd0);

    issue(u_type(20'h12345, 7, 7'b0110111), 32'h24, s);
    issue(u_type(20'h00001, 8, 7'b0010111), 32'h100, s);
    issue({7'd0, 5'd7, 5'd8, 3'b010, 5'd0, 7'b0100011}, 32'h104, s);
    check("store_no_stall", 32'(s), 32'd0);
    issue(r_type(7'h00, 8, 7, 3'b000, 9), 32'h108, s);
    issue(i_type(12'hFFF, 9, 3'b000, 10), 32'h10C, s);
    issue(i_type(12'h403, 10, 3'b101, 11), 32'h110, s);

    pc = 32'h200;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      int rd, ra, rb;
      rd = $urandom_range(5);
      ra = $urandom_range(5);
      rb = $urandom_range(5);
      case ($urandom_range(6))
        0: ins = i_type(12'($urandom), ra, 3'b000, rd);
        1: ins = r_type(7'h00, rb, ra, 3'b000, rd);
        2: ins = r_type(7'h20, rb, ra, 3'b000, rd);
        3: ins = r_type(7'h00, rb, ra, 3'b100, rd);
        4: ins = i_type(12'($urandom_range(31)), ra, 3'b001, rd);
        5: ins = u_type(20'($urandom), rd, 7'b0010111);
        default: ins = {7'd0, 5'(rb), 5'(ra), 3'b010, 5'd0, 7'b0100011};
      endcase
      issue(ins, pc, s);
      pc += 4;
    end

    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("idle_enable", {31'b0, alu_enable}, 32'd0);
    check("final_x1", env_rf[1], g_rf[1]);
    check("final_x5", env_rf[5], g_rf[5]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
